// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration controller.
//   preset_t      : one PLL preset (IDSEL/FBDSEL/ODSEL dynamic-port codes)
//   preset_tbl_t  : default preset table, entry 0 is the power-up preset
//   state_t       : sequencer FSM state encoding
//   preset_lookup : table read with out-of-range indices folded to entry 0
package pll_cfg_pkg;

  localparam int PKG_NUM_MODES = 4;
  localparam int PKG_IW        = 2;

  typedef struct packed {
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [5:0] odsel;
  } preset_t;

  typedef preset_t preset_tbl_t [PKG_NUM_MODES];

  // Codes are already in the PLL dynamic-port encoding.
  localparam preset_tbl_t PRESET_TBL = '{
    '{idsel: 6'h01, fbdsel: 6'h10, odsel: 6'h02},
    '{idsel: 6'h02, fbdsel: 6'h18, odsel: 6'h03},
    '{idsel: 6'h03, fbdsel: 6'h28, odsel: 6'h01},
    '{idsel: 6'h04, fbdsel: 6'h30, odsel: 6'h04}
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_HOLD,
    S_WAIT_LOCK,
    S_STABLE,
    S_HALT
  } state_t;

  function automatic preset_t preset_lookup(input logic [31:0] m);
    if (m < 32'(PKG_NUM_MODES)) return PRESET_TBL[m[PKG_IW-1:0]];
    return PRESET_TBL[0];
  endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
//   clk   : destination clock
//   reset : synchronous active-high reset, clears both flops
//   d     : asynchronous input
//   q     : synchronised output (two clk edges of latency)
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration sequencer.
// Applies a preset's dynamic-port codes, pulses the PLL reset, waits for a
// stable lock, retries on timeout and falls back to the last good preset
// (or halts) when a mode will not lock.
//   clkin      : free-running reference clock
//   reset      : synchronous active-high reset (starts a mode-0 power-up)
//   mode_sel   : requested preset index, qualified by mode_req
//   mode_req   : single-cycle request strobe
//   pll_lock   : PLL lock, asynchronous
//   pll_reset  : PLL reset pin
//   idsel/fbdsel/odsel : PLL dynamic-port codes
//   cur_mode   : last successfully locked mode
//   busy       : sequence in progress
//   done       : one-cycle pulse on declared lock
//   clk_valid  : PLL output usable
//   err        : sticky failure flag
//   req_rej    : one-cycle pulse for an out-of-range request
module pll_reconfig_ctrl
  import pll_cfg_pkg::*;
#(
  parameter int NUM_MODES    = 4,
  parameter int RST_HOLD     = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_STABLE  = 256,
  parameter int MAX_RETRY    = 3,
  localparam int MW = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
  input  logic          clkin,
  input  logic          reset,
  input  logic [MW-1:0] mode_sel,
  input  logic          mode_req,
  input  logic          pll_lock,
  output logic          pll_reset,
  output logic [5:0]    idsel,
  output logic [5:0]    fbdsel,
  output logic [5:0]    odsel,
  output logic [MW-1:0] cur_mode,
  output logic          busy,
  output logic          done,
  output logic          clk_valid,
  output logic          err,
  output logic          req_rej
);

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  state_t        state;
  logic [MW-1:0] target;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] wait_cnt;
  logic [SW-1:0] stab_cnt;
  logic [RW-1:0] retry_cnt;
  // Set while sequencing a mode already known good (power-up, fallback,
  // lock-loss recovery): exhausting retries there has nowhere left to go.
  logic          fb;
  logic          lock_s;
  logic          mode_ok;

  sync2 u_lock_sync (
    .clk   (clkin),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign mode_ok = (32'(mode_sel) < 32'(NUM_MODES));

  always_ff @(posedge clkin) begin
    if (reset) begin
      state     <= S_APPLY;
      target    <= '0;
      cur_mode  <= '0;
      hold_cnt  <= '0;
      wait_cnt  <= '0;
      stab_cnt  <= '0;
      retry_cnt <= '0;
      fb        <= 1'b1;
      {idsel, fbdsel, odsel} <= PRESET_TBL[0];
      pll_reset <= 1'b1;
      busy      <= 1'b1;
      done      <= 1'b0;
      clk_valid <= 1'b0;
      err       <= 1'b0;
      req_rej   <= 1'b0;
    end else begin
      done    <= 1'b0;
      req_rej <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mode_req && mode_ok) begin
            target    <= mode_sel;
            err       <= 1'b0;
            fb        <= 1'b0;
            retry_cnt <= '0;
            busy      <= 1'b1;
            state     <= S_APPLY;
          end else begin
            if (mode_req) req_rej <= 1'b1;
            // Lock lost: re-acquire without touching the PLL reset.
            if (!lock_s) begin
              clk_valid <= 1'b0;
              busy      <= 1'b1;
              fb        <= 1'b1;
              retry_cnt <= '0;
              wait_cnt  <= '0;
              state     <= S_WAIT_LOCK;
            end
          end
        end
        S_APPLY: begin
          {idsel, fbdsel, odsel} <= preset_lookup(32'(target));
          pll_reset <= 1'b1;
          busy      <= 1'b1;
          clk_valid <= 1'b0;
          hold_cnt  <= '0;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_cnt >= HW'(RST_HOLD - 1)) begin
            pll_reset <= 1'b0;
            wait_cnt  <= '0;
            state     <= S_WAIT_LOCK;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            // The cycle that first sees lock counts toward stability.
            stab_cnt <= SW'(1);
            state    <= S_STABLE;
          end else if (wait_cnt >= TW'(LOCK_TIMEOUT - 1)) begin
            if ((32'(retry_cnt) + 32'd1) < 32'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + RW'(1);
              state     <= S_APPLY;
            end else if (!fb) begin
              err       <= 1'b1;
              target    <= cur_mode;
              retry_cnt <= '0;
              fb        <= 1'b1;
              state     <= S_APPLY;
            end else begin
              pll_reset <= 1'b1;
              busy      <= 1'b0;
              clk_valid <= 1'b0;
              err       <= 1'b1;
              retry_cnt <= '0;
              state     <= S_HALT;
            end
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            wait_cnt <= '0;
            state    <= S_WAIT_LOCK;
          end else if (stab_cnt >= SW'(LOCK_STABLE - 1)) begin
            done      <= 1'b1;
            clk_valid <= 1'b1;
            busy      <= 1'b0;
            cur_mode  <= target;
            retry_cnt <= '0;
            fb        <= 1'b0;
            state     <= S_IDLE;
          end else begin
            stab_cnt <= stab_cnt + SW'(1);
          end
        end
        S_HALT: begin
          if (mode_req && mode_ok) begin
            target    <= mode_sel;
            err       <= 1'b0;
            fb        <= 1'b0;
            retry_cnt <= '0;
            busy      <= 1'b1;
            state     <= S_APPLY;
          end else if (mode_req) begin
            req_rej <= 1'b1;
          end
        end
        default: state <= S_APPLY;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl (NUM_MODES=3, RST_HOLD=4,
// LOCK_STABLE=8, LOCK_TIMEOUT=100, MAX_RETRY=2). Expected lock results are
// queued when a request is issued and compared when done pulses.
module tb_pll_reconfig_ctrl;

  logic       clkin = 1'b0;
  logic       reset, mode_req, pll_lock;
  logic [1:0] mode_sel;
  logic       pll_reset;
  logic [5:0] idsel, fbdsel, odsel;
  logic [1:0] cur_mode;
  logic       busy, done, clk_valid, err, req_rej;
  logic [17:0] codes;

  typedef struct {
    logic [1:0]  mode;
    logic [17:0] codes;
  } exp_t;

  exp_t        exp_q[$];
  logic [17:0] tbl [3];
  int          checks = 0;
  int          errors = 0;

  assign codes = {idsel, fbdsel, odsel};

  always #5 clkin = ~clkin;

  pll_reconfig_ctrl #(
    .NUM_MODES(3), .RST_HOLD(4), .LOCK_TIMEOUT(100), .LOCK_STABLE(8), .MAX_RETRY(2)
  ) dut (
    .clkin(clkin), .reset(reset), .mode_sel(mode_sel), .mode_req(mode_req),
    .pll_lock(pll_lock), .pll_reset(pll_reset), .idsel(idsel), .fbdsel(fbdsel),
    .odsel(odsel), .cur_mode(cur_mode), .busy(busy), .done(done),
    .clk_valid(clk_valid), .err(err), .req_rej(req_rej)
  );

  task automatic tick();
    @(negedge clkin);
  endtask

  task automatic push_exp(input logic [1:0] m);
    exp_t e;
    e.mode  = m;
    e.codes = tbl[m];
    exp_q.push_back(e);
  endtask

  // Runs until done pulses or the budget expires; n = ticks taken,
  // rises = pll_reset 0->1 transitions seen on the way.
  task automatic run_until_done(input int budget, output int n, output int rises, output bit got);
    logic prev;
    prev = pll_reset; n = 0; rises = 0; got = 1'b0;
    while (n < budget && !got) begin
      tick(); n++;
      if (pll_reset && !prev) rises++;
      prev = pll_reset;
      if (done) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mode_req = 1'b0; mode_sel = 2'd0; pll_lock = 1'b0;
    repeat (3) tick();
    checks++; if ({pll_reset, busy, done, clk_valid, err, req_rej} !== 6'b110000) begin errors++; $display("FAIL rst_flags got %b want 110000", {pll_reset, busy, done, clk_valid, err, req_rej}); end
    checks++; if (cur_mode !== 2'd0) begin errors++; $display("FAIL rst_mode got %0d want 0", cur_mode); end
    checks++; if (codes !== tbl[0]) begin errors++; $display("FAIL rst_codes got %h want %h", codes, tbl[0]); end
  endtask

  task automatic test_powerup();
    int hi, n, r; bit got; exp_t e;
    reset = 1'b0; hi = 0;
    push_exp(2'd0);
    for (int i = 0; i < 20; i++) begin tick(); if (pll_reset) hi++; end
    checks++; if (hi !== 4) begin errors++; $display("FAIL pu_rst_len got %0d want 4", hi); end
    checks++; if ({busy, clk_valid, done} !== 3'b100) begin errors++; $display("FAIL pu_wait got %b want 100", {busy, clk_valid, done}); end
    pll_lock = 1'b1;
    run_until_done(40, n, r, got);
    checks++; if (!got || n !== 10) begin errors++; $display("FAIL pu_done_lat got %0d (seen %0d) want 10", n, got); end
    e = exp_q.pop_front();
    checks++; if (cur_mode !== e.mode) begin errors++; $display("FAIL pu_mode got %0d want %0d", cur_mode, e.mode); end
    checks++; if (codes !== e.codes) begin errors++; $display("FAIL pu_codes got %h want %h", codes, e.codes); end
    checks++; if ({clk_valid, busy} !== 2'b10) begin errors++; $display("FAIL pu_valid got %b want 10", {clk_valid, busy}); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL pu_done_pulse got %b want 0", done); end
  endtask

  task automatic test_no_lock();
    int k, err_k, rises; bit got, seen_err; logic prev; exp_t e;
    mode_sel = 2'd1; mode_req = 1'b1; pll_lock = 1'b0;
    push_exp(2'd0);
    tick(); mode_req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nl_busy got %b want 1", busy); end
    k = 0; err_k = -1; rises = 0; got = 1'b0; seen_err = 1'b0; prev = pll_reset;
    while (k < 400 && !got) begin
      tick(); k++;
      if (pll_reset && !prev) rises++;
      prev = pll_reset;
      if (err && !seen_err) begin seen_err = 1'b1; err_k = k; pll_lock = 1'b1; end
      if (done) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL nl_done got timeout want done"); end
    checks++; if (err_k !== 210) begin errors++; $display("FAIL nl_err_time got %0d want 210", err_k); end
    checks++; if (rises !== 3) begin errors++; $display("FAIL nl_attempts got %0d want 3", rises); end
    e = exp_q.pop_front();
    checks++; if (cur_mode !== e.mode) begin errors++; $display("FAIL nl_mode got %0d want %0d", cur_mode, e.mode); end
    checks++; if (codes !== e.codes) begin errors++; $display("FAIL nl_codes got %h want %h", codes, e.codes); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL nl_err_sticky got %b want 1", err); end
  endtask

  task automatic test_switch();
    int hi; bit got; logic [17:0] first; exp_t e;
    mode_sel = 2'd2; mode_req = 1'b1;
    push_exp(2'd2);
    tick(); mode_req = 1'b0;
    checks++; if ({busy, err} !== 2'b10) begin errors++; $display("FAIL sw_start got %b want 10", {busy, err}); end
    hi = 0; got = 1'b0; first = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (pll_reset) begin hi++; if (hi == 1) first = codes; end
      if (done) got = 1'b1;
    end
    checks++; if (!got || hi !== 4) begin errors++; $display("FAIL sw_rst_len got %0d (done %0d) want 4", hi, got); end
    checks++; if (first !== tbl[2]) begin errors++; $display("FAIL sw_apply_codes got %h want %h", first, tbl[2]); end
    e = exp_q.pop_front();
    checks++; if (cur_mode !== e.mode) begin errors++; $display("FAIL sw_mode got %0d want %0d", cur_mode, e.mode); end
    checks++; if (codes !== e.codes) begin errors++; $display("FAIL sw_codes got %h want %h", codes, e.codes); end
  endtask

  task automatic test_reject();
    int n, r; bit got; exp_t e;
    mode_sel = 2'd3; mode_req = 1'b1;
    tick(); mode_req = 1'b0;
    checks++; if ({req_rej, busy} !== 2'b10) begin errors++; $display("FAIL rj_pulse got %b want 10", {req_rej, busy}); end
    checks++; if (cur_mode !== 2'd2) begin errors++; $display("FAIL rj_mode got %0d want 2", cur_mode); end
    tick();
    checks++; if ({req_rej, busy} !== 2'b00) begin errors++; $display("FAIL rj_clear got %b want 00", {req_rej, busy}); end
    mode_sel = 2'd2; mode_req = 1'b1;
    push_exp(2'd2);
    tick(); mode_req = 1'b0;
    tick(); tick();
    mode_sel = 2'd0; mode_req = 1'b1;
    tick(); mode_req = 1'b0;
    checks++; if (req_rej !== 1'b0) begin errors++; $display("FAIL rj_busy_rej got %b want 0", req_rej); end
    run_until_done(40, n, r, got);
    checks++; if (!got || r !== 0) begin errors++; $display("FAIL rj_busy_ignore got rises %0d done %0d want 0 1", r, got); end
    e = exp_q.pop_front();
    checks++; if (cur_mode !== e.mode) begin errors++; $display("FAIL rj_final_mode got %0d want %0d", cur_mode, e.mode); end
  endtask

  task automatic test_loss();
    int n, r; bit got; exp_t e;
    pll_lock = 1'b0; n = 0;
    while (clk_valid && n < 10) begin tick(); n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL ls_valid_drop got %0d want 3", n); end
    checks++; if ({busy, pll_reset} !== 2'b10) begin errors++; $display("FAIL ls_state got %b want 10", {busy, pll_reset}); end
    repeat (10) tick();
    pll_lock = 1'b1;
    push_exp(2'd2);
    run_until_done(40, n, r, got);
    checks++; if (!got || r !== 0) begin errors++; $display("FAIL ls_recover got rises %0d done %0d want 0 1", r, got); end
    e = exp_q.pop_front();
    checks++; if ({cur_mode, clk_valid} !== {e.mode, 1'b1}) begin errors++; $display("FAIL ls_mode got %0d/%0d want %0d/1", cur_mode, clk_valid, e.mode); end
  endtask

  task automatic test_glitch();
    int n, r; bit got, seen_hi; exp_t e;
    mode_sel = 2'd1; mode_req = 1'b1;
    push_exp(2'd1);
    tick(); mode_req = 1'b0;
    n = 0; seen_hi = 1'b0;
    while (n < 20) begin
      tick(); n++;
      if (pll_reset) seen_hi = 1'b1;
      else if (seen_hi) break;
    end
    repeat (5) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    run_until_done(30, n, r, got);
    checks++; if (!got || n !== 10) begin errors++; $display("FAIL gl_done_lat got %0d (done %0d) want 10", n, got); end
    checks++; if (r !== 0) begin errors++; $display("FAIL gl_no_reset got %0d want 0", r); end
    e = exp_q.pop_front();
    checks++; if (cur_mode !== e.mode) begin errors++; $display("FAIL gl_mode got %0d want %0d", cur_mode, e.mode); end
    checks++; if (codes !== e.codes) begin errors++; $display("FAIL gl_codes got %h want %h", codes, e.codes); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL gl_err got %b want 0", err); end
  endtask

  task automatic test_reset_mid();
    int n, r; bit got; exp_t e;
    mode_sel = 2'd2; mode_req = 1'b1; pll_lock = 1'b0;
    tick(); mode_req = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    checks++; if ({pll_reset, busy, done, clk_valid, err, req_rej} !== 6'b110000) begin errors++; $display("FAIL rm_flags got %b want 110000", {pll_reset, busy, done, clk_valid, err, req_rej}); end
    checks++; if ({cur_mode, codes} !== {2'd0, tbl[0]}) begin errors++; $display("FAIL rm_mode_codes got %0d/%h want 0/%h", cur_mode, codes, tbl[0]); end
    reset = 1'b0; pll_lock = 1'b1;
    push_exp(2'd0);
    run_until_done(60, n, r, got);
    checks++; if (!got) begin errors++; $display("FAIL rm_powerup got timeout want done"); end
    e = exp_q.pop_front();
    checks++; if ({cur_mode, codes} !== {e.mode, e.codes}) begin errors++; $display("FAIL rm_final got %0d/%h want %0d/%h", cur_mode, codes, e.mode, e.codes); end
  endtask

  task automatic test_halt();
    int k, n, r; bit got; exp_t e;
    reset = 1'b1; pll_lock = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick(); k = 0;
    while (busy && k < 400) begin tick(); k++; end
    checks++; if (k !== 209) begin errors++; $display("FAIL ht_time got %0d want 209", k); end
    repeat (5) tick();
    checks++; if ({pll_reset, busy, clk_valid, err} !== 4'b1001) begin errors++; $display("FAIL ht_state got %b want 1001", {pll_reset, busy, clk_valid, err}); end
    pll_lock = 1'b1; mode_sel = 2'd1; mode_req = 1'b1;
    push_exp(2'd1);
    tick(); mode_req = 1'b0;
    checks++; if ({busy, err} !== 2'b10) begin errors++; $display("FAIL ht_exit got %b want 10", {busy, err}); end
    run_until_done(60, n, r, got);
    checks++; if (!got) begin errors++; $display("FAIL ht_relock got timeout want done"); end
    e = exp_q.pop_front();
    checks++; if ({cur_mode, codes} !== {e.mode, e.codes}) begin errors++; $display("FAIL ht_final got %0d/%h want %0d/%h", cur_mode, codes, e.mode, e.codes); end
  endtask

  initial begin
    tbl[0] = {6'h01, 6'h10, 6'h02};
    tbl[1] = {6'h02, 6'h18, 6'h03};
    tbl[2] = {6'h03, 6'h28, 6'h01};
    test_reset();
    test_powerup();
    test_no_lock();
    test_switch();
    test_reject();
    test_loss();
    test_glitch();
    test_reset_mid();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 Parameter NUM_MODES, 4, number of selectable PLL presets; must be at least 2.
REQ-002 Parameter RST_HOLD, 16, number of cycles pll_reset is held high per attempt.
REQ-003 Parameter LOCK_TIMEOUT, 65535, cycles allowed for lock to appear after pll_reset falls.
REQ-004 Parameter LOCK_STABLE, 256, consecutive synchronised-lock cycles required before lock is declared.
REQ-005 Parameter MAX_RETRY, 3, attempts per mode before fallback.
REQ-006 Port list, in order:
- clkin  in  1  sole clock; free-running reference, not a PLL output.
- reset  in  1  synchronous, active-high.
- mode_sel  in  MW=max(1,clog2(NUM_MODES))  requested preset index.
- mode_req  in  1  single-cycle request strobe.
- pll_lock  in  1  PLL LOCK, asynchronous to clkin.
- pll_reset  out  1  drives the PLL RESET pin.
- idsel, fbdsel, odsel  out  6 each  drive the PLL IDSEL/FBDSEL/ODSEL dynamic ports.
- cur_mode  out  MW  last successfully locked mode.
- busy  out  1  sequencing in progress.
- done  out  1  one-cycle pulse on declared lock.
- clk_valid  out  1  PLL output usable downstream.
- err  out  1  sticky failure flag.
- req_rej  out  1  one-cycle pulse for a rejected request.

Function
REQ-007 pll_lock SHALL pass through a 2-flop synchroniser; all lock decisions SHALL use the synchronised value (lock_s).
REQ-008 The FSM SHALL have the states IDLE, APPLY, HOLD, WAIT_LOCK, STABLE and HALT.
REQ-009 APPLY (1 cycle): register the target mode's table codes onto idsel/fbdsel/odsel, assert pll_reset and busy, deassert clk_valid; go to HOLD.
REQ-010 HOLD: keep pll_reset=1 for exactly RST_HOLD cycles, with the codes stable throughout; go to WAIT_LOCK with pll_reset=0.
REQ-011 WAIT_LOCK: count cycles.
- lock_s=1 -> STABLE.
- Count reaches LOCK_TIMEOUT -> increment the retry counter and go to APPLY, while retries < MAX_RETRY.
- Otherwise -> fallback (REQ-014).
REQ-012 STABLE: count consecutive lock_s=1 cycles.
- lock_s=0 -> return to WAIT_LOCK with the timeout counter restarted; pll_reset is not asserted.
- Count reaches LOCK_STABLE -> IDLE, same edge: done=1 for one cycle, clk_valid=1, busy=0, cur_mode=target, retry counter cleared.
REQ-013 IDLE, mode_req=1:
- mode_sel<NUM_MODES -> latch target=mode_sel, clear err, go to APPLY; a request equal to cur_mode is still honoured.
- mode_sel>=NUM_MODES -> req_rej=1 for one cycle, no state change.
REQ-014 Retries exhausted on a requested mode: set err=1, set target=cur_mode (last good), clear retries, go to APPLY (fallback).
REQ-015 Retries exhausted during fallback or during the power-up sequence: go to HALT.
- HALT holds pll_reset=1, busy=0, clk_valid=0, err=1.
- Only mode_req (valid) or reset exits HALT.
REQ-016 mode_req while busy SHALL be ignored, with no queue and no req_rej.
REQ-017 lock_s=0 in IDLE: clk_valid=0 on the next edge; go to WAIT_LOCK with busy=1 and no pll_reset; normal timeout/retry rules then apply.
REQ-018 Preset table (per mode: idsel, fbdsel, odsel) SHALL hold codes already in the PLL dynamic-port encoding; mode 0 SHALL be the power-up preset.
REQ-019 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-020 Counters SHALL be sized from their parameters, SHALL saturate and SHALL never wrap.

Reset
REQ-021 While reset=1, outputs SHALL be: pll_reset=1, busy=1, done=0, clk_valid=0, err=0, req_rej=0, cur_mode=0, codes=table[0], state=APPLY with target 0.
REQ-022 Reset asserted mid-sequence SHALL abandon the sequence; after release, a full power-up sequence for mode 0 runs.

Structure
REQ-023 The shared package pll_cfg_pkg SHALL hold the preset table type, the default NUM_MODES-entry table constant, and the FSM state enum.
REQ-024 One sub-module, sync2 (the 2-flop synchroniser), SHALL be instantiated for pll_lock; everything else stays in one module.

Verification
Bench parameters: NUM_MODES=3, RST_HOLD=4, LOCK_STABLE=8, LOCK_TIMEOUT=100, MAX_RETRY=2.
REQ-025 Power-up: release reset, raise pll_lock 20 cycles later -> pll_reset high exactly 4 cycles after APPLY; done and clk_valid exactly 2+8 cycles after the pll_lock rise; cur_mode=0.
REQ-026 Switch: in IDLE pulse mode_req with mode_sel=2 -> codes=table[2] one cycle later, pll_reset high 4 cycles, cur_mode=2 at done.
REQ-027 No lock: request mode 1 with pll_lock held 0 -> 2 attempts of 100 cycles, err=1, re-sequence of mode 0; lock then given -> done, cur_mode=0, err remains 1.
REQ-028 Glitch: drop pll_lock for 1 cycle at STABLE count 5 -> count restarts, no pll_reset, done 10 cycles after pll_lock returns.
REQ-029 Rejects: mode_sel=3 in IDLE -> req_rej pulse, no change; mode_req during HOLD -> ignored.
REQ-030 Loss/reset: drop pll_lock in IDLE -> clk_valid=0 within 3 cycles, recovery without pll_reset; synchronous reset during WAIT_LOCK -> outputs per REQ-021 on the next edge.
